// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_sequencer : FETCH/EXEC program-counter controller with beq/jump and   |
// |                address-limit halt.                    Revision: 1.0      |
// +--------------------------------------------------------------------------+
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] ADDR_LIMIT = 32'd256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        beq_signal,
  input  logic [31:0] beq_adr,
  input  logic        jmp_signal,
  input  logic [25:0] jmp_adr,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        halted,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic [31:0] w_seq;
  logic [31:0] w_next_pc;

  // Jump takes priority over a taken branch when both are flagged.
  always_comb begin
    w_seq = r_pc + 32'd1;
    if (jmp_signal) begin
      w_next_pc = {w_seq[31:26], jmp_adr};
    end else if (beq_signal) begin
      w_next_pc = w_seq + beq_adr;
    end else begin
      w_next_pc = w_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_retired <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pc <= RESET_PC;
          if (start) begin
            r_state <= (RESET_PC >= ADDR_LIMIT) ? S_HALT : S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + 32'd1;
            r_state   <= (w_next_pc >= ADDR_LIMIT) ? S_HALT : S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc            = r_pc;
  assign retired_count = r_retired;
  assign imem_req      = (r_state == S_FETCH);
  assign instr_valid   = (r_state == S_EXEC);
  assign halted        = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_sequencer : directed bench; dut A halts at 4, dut B runs wide.     |
// |                                                      Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        beq_signal = 1'b0;
  logic [31:0] beq_adr = 32'd0;
  logic        jmp_signal = 1'b0;
  logic [25:0] jmp_adr = 26'd0;
  logic        imem_ready = 1'b1;

  logic [31:0] pc_a, cnt_a, pc_b, cnt_b;
  logic        req_a, vld_a, hlt_a, req_b, vld_b, hlt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'd0), .ADDR_LIMIT(32'd4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .beq_signal(beq_signal), .beq_adr(beq_adr), .jmp_signal(jmp_signal),
    .jmp_adr(jmp_adr), .imem_ready(imem_ready), .pc(pc_a), .imem_req(req_a),
    .instr_valid(vld_a), .halted(hlt_a), .retired_count(cnt_a)
  );

  pc_sequencer #(.RESET_PC(32'd0), .ADDR_LIMIT(32'hFFFF_FFFF)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .beq_signal(beq_signal), .beq_adr(beq_adr), .jmp_signal(jmp_signal),
    .jmp_adr(jmp_adr), .imem_ready(imem_ready), .pc(pc_b), .imem_req(req_b),
    .instr_valid(vld_b), .halted(hlt_b), .retired_count(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From FETCH: enter EXEC, present redirect inputs, retire on the next edge.
  task automatic step(input logic b, input logic [31:0] ba, input logic j, input logic [25:0] ja);
    @(negedge clk);
    beq_signal = b; beq_adr = ba; jmp_signal = j; jmp_adr = ja;
    @(negedge clk);
    beq_signal = 1'b0; beq_adr = 32'd0; jmp_signal = 1'b0; jmp_adr = 26'd0;
  endtask

  task automatic flags_b(input string tag, input logic rq, input logic vl, input logic ht);
    check_eq({tag, "_req"}, {31'd0, req_b}, {31'd0, rq});
    check_eq({tag, "_vld"}, {31'd0, vld_b}, {31'd0, vl});
    check_eq({tag, "_hlt"}, {31'd0, hlt_b}, {31'd0, ht});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_pc_a", pc_a, 32'd0);
    check_eq("rst_cnt_a", cnt_a, 32'd0);
    check_eq("rst_hlt_a", {31'd0, hlt_a}, 32'd0);
    flags_b("rst_b", 1'b0, 1'b0, 1'b0);

    // Sequential run; dut A halts at its limit of 4.
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flags_b("fetch0", 1'b1, 1'b0, 1'b0);
    check_eq("fetch0_pc", pc_b, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("seq_exec_vld", {31'd0, vld_a}, 32'd1);
      check_eq("seq_exec_pc", pc_a, i);
      @(negedge clk);
      check_eq("seq_next_pc", pc_a, i + 1);
    end
    check_eq("lim_hlt_a", {31'd0, hlt_a}, 32'd1);
    check_eq("lim_pc_a", pc_a, 32'd4);
    check_eq("lim_cnt_a", cnt_a, 32'd4);
    check_eq("lim_req_a", {31'd0, req_a}, 32'd0);
    flags_b("wide_fetch4", 1'b1, 1'b0, 1'b0);

    // Redirects on dut B.
    step(1'b0, 32'd0, 1'b0, 26'd0);
    check_eq("pc5", pc_b, 32'd5);
    step(1'b1, 32'hFFFF_FFFD, 1'b0, 26'd0);
    check_eq("beq_neg3", pc_b, 32'd3);
    step(1'b1, 32'd1, 1'b0, 26'd0);
    check_eq("back_to_5", pc_b, 32'd5);
    step(1'b1, 32'd10, 1'b0, 26'd0);
    check_eq("beq_plus10", pc_b, 32'd16);
    step(1'b1, 32'h03FF_FFF6, 1'b0, 26'd0);
    check_eq("beq_far", pc_b, 32'h0400_0007);
    step(1'b1, 32'd5, 1'b1, 26'h000_0010);
    check_eq("jmp_wins", pc_b, 32'h0400_0010);
    check_eq("cnt_10", cnt_b, 32'd10);
    step(1'b1, 32'hFBFF_FFF1, 1'b0, 26'd0);
    check_eq("wrap_to_2", pc_b, 32'd2);

    // Memory wait, then stall with redirects present (must be ignored).
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flags_b("fwait", 1'b1, 1'b0, 1'b0);
      check_eq("fwait_pc", pc_b, 32'd2);
    end
    imem_ready = 1'b1; stall = 1'b1;
    @(negedge clk);
    beq_signal = 1'b1; beq_adr = 32'd100; jmp_signal = 1'b1; jmp_adr = 26'h3FF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      flags_b("stall", 1'b0, 1'b1, 1'b0);
      check_eq("stall_pc", pc_b, 32'd2);
      check_eq("stall_cnt", cnt_b, 32'd11);
    end
    stall = 1'b0; beq_signal = 1'b0; jmp_signal = 1'b0; beq_adr = 32'd0; jmp_adr = 26'd0;
    @(negedge clk);
    check_eq("release_pc", pc_b, 32'd3);
    check_eq("release_cnt", cnt_b, 32'd12);
    flags_b("release", 1'b1, 1'b0, 1'b0);

    // Restart and reset in the middle of EXEC at pc 9.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) step(1'b0, 32'd0, 1'b0, 26'd0);
    @(negedge clk);
    flags_b("exec9", 1'b0, 1'b1, 1'b0);
    check_eq("exec9_pc", pc_b, 32'd9);
    check_eq("exec9_cnt", cnt_b, 32'd9);
    reset = 1'b1;
    @(negedge clk);
    flags_b("midrst", 1'b0, 1'b0, 1'b0);
    check_eq("midrst_pc", pc_b, 32'd0);
    check_eq("midrst_cnt", cnt_b, 32'd0);
    check_eq("midrst_hlt_a", {31'd0, hlt_a}, 32'd0);

    // Restart dut A to halt, then pulse start.
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) step(1'b0, 32'd0, 1'b0, 26'd0);
    check_eq("rehalt_a", {31'd0, hlt_a}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("hold_hlt_a", {31'd0, hlt_a}, 32'd1);
    check_eq("hold_req_a", {31'd0, req_a}, 32'd0);
    check_eq("hold_pc_a", pc_a, 32'd4);
    check_eq("hold_cnt_a", cnt_a, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/sequence controller for the single-cycle MIPS datapath's program counter.
- Replaces the free-running per-clock PC update with an explicit FSM that handshakes with instruction memory, honours stalls, and applies beq/jump redirects once per retired instruction.
- Stops at a programmable instruction-address limit.
- Sits between the control unit (beq_signal/jmp_signal), the sign-extended branch offset, and the instruction memory address port.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset and while IDLE (word address).
- ADDR_LIMIT, 32'd256, first word address that must not be fetched; reaching it halts.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin execution; sampled only in IDLE
- stall  input  1  hold current instruction in EXEC (no PC update, no retire)
- beq_signal  input  1  taken-branch indication for current instruction
- beq_adr  input  32  signed word offset, added to PC+1
- jmp_signal  input  1  jump indication for current instruction
- jmp_adr  input  26  jump target field
- imem_ready  input  1  instruction memory accepts/returns current fetch
- pc  output  32  current instruction word address (registered)
- imem_req  output  1  fetch request, high only in FETCH (decoded from state)
- instr_valid  output  1  high only in EXEC; instruction at pc is being executed
- halted  output  1  high only in HALT
- retired_count  output  32  number of instructions retired since reset

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset takes priority over everything, including mid-fetch or mid-EXEC:
  - state=IDLE, pc=RESET_PC, retired_count=0.
  - imem_req=0, instr_valid=0, halted=0.
- States: IDLE, FETCH, EXEC, HALT. Outputs are Moore (state decode only).
- IDLE:
  - pc held at RESET_PC.
  - start=1 -> FETCH; if RESET_PC >= ADDR_LIMIT, go to HALT instead.
- FETCH:
  - imem_req=1, pc stable.
  - imem_ready=1 at the edge -> EXEC; otherwise remain in FETCH indefinitely with pc and req held.
- EXEC:
  - instr_valid=1.
  - stall=1 -> remain in EXEC; pc, retired_count unchanged; beq/jmp inputs ignored that cycle.
  - stall=0 -> retire: pc<=next_pc, retired_count<=retired_count+1, then next state as below.
  - next_pc >= ADDR_LIMIT (unsigned) -> HALT; else -> FETCH.
- next_pc, with seq = pc+1 (mod 2^32):
  - jmp_signal=1 -> {seq[31:26], jmp_adr}. Jump has priority when both jmp_signal and beq_signal are 1.
  - else beq_signal=1 -> seq + beq_adr (32-bit two's-complement, wraps mod 2^32, no overflow flag).
  - else -> seq.
- HALT:
  - halted=1, pc holds the final next_pc value, retired_count frozen.
  - Exit only via reset; start is ignored.
- start outside IDLE is ignored. stall outside EXEC is ignored. beq/jmp are sampled only on the retiring EXEC edge.
- retired_count wraps 2^32-1 -> 0.
- Minimum throughput: 2 cycles per instruction with imem_ready tied high (FETCH, EXEC).

Test Plan:
- Reset, then start with imem_ready=1 and no branches:
  - pc steps 0,1,2,... with one increment every 2 cycles.
  - With ADDR_LIMIT=4, HALT is entered with pc=4, retired_count=4, halted=1.
- At pc=5, EXEC with beq_signal=1, beq_adr=32'hFFFFFFFD (-3) -> next pc=3.
- At pc=5, beq_adr=10 -> next pc=16.
- At pc=32'h0400_0007, jmp_signal=1, beq_signal=1, jmp_adr=26'h0000010 -> pc=32'h0400_0010 (jump wins over beq).
- At pc=2, imem_ready low for 3 cycles:
  - FETCH held, imem_req=1, pc=2 throughout.
  - Then stall=1 for 2 EXEC cycles -> pc stays 2, retired_count unchanged.
  - Release -> pc=3, retired_count incremented by exactly 1.
- Assert reset during EXEC at pc=9 with retired_count=9 -> next cycle IDLE, pc=0, retired_count=0, all flags 0.
- Restart, then halt, then pulse start -> remains HALT.
